// File: rtl/logreg_theta_update.sv
// Serial gradient-descent step for an 8-element byte weight vector.
// One element is updated per clock; the learning rate is 2^-LR_SHIFT.
module logreg_theta_update #(
  parameter int LR_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] x,
  input  logic [7:0]  h,
  input  logic [7:0]  y,
  input  logic        start,
  output logic        ready,
  input  logic        teta_load,
  input  logic [63:0] teta_in,
  output logic [63:0] teta,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         idx_reg;
  logic [63:0]        x_reg;
  logic signed [8:0]  err_reg;
  logic [63:0]        teta_vec;
  logic               load_en;
  logic               capture;

  logic [7:0]         x_j, teta_j, new_val;
  logic signed [17:0] prod, delta;
  logic signed [18:0] diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        // A weight load has priority over a simultaneous start.
        if (teta_load) begin
          load_en = 1'b1;
        end else if (start) begin
          capture    = 1'b1;
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        if (idx_reg == 3'd7) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= 3'd0;
      x_reg   <= 64'h0;
      err_reg <= 9'sd0;
    end else if (capture) begin
      idx_reg <= 3'd0;
      x_reg   <= x;
      err_reg <= $signed({1'b0, h}) - $signed({1'b0, y});
    end else if (state_reg == UPDATE) begin
      idx_reg <= idx_reg + 3'd1;
    end
  end

  assign x_j    = x_reg[{idx_reg, 3'b000} +: 8];
  assign teta_j = teta_vec[{idx_reg, 3'b000} +: 8];

  // |err * x_j| <= 65025, so 18 signed bits hold the product without overflow.
  assign prod  = 18'(err_reg) * 18'($signed({1'b0, x_j}));
  assign delta = prod >>> LR_SHIFT;
  assign diff  = $signed({11'b0, teta_j}) - 19'(delta);

  always_comb begin
    new_val = diff[7:0];
    if (diff < 19'sd0)        new_val = 8'h00;
    else if (diff > 19'sd255) new_val = 8'hFF;
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_elem
      logic [7:0] elem_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          elem_reg <= 8'h00;
        end else if (load_en) begin
          elem_reg <= teta_in[gi*8 +: 8];
        end else if (state_reg == UPDATE && idx_reg == 3'(gi)) begin
          elem_reg <= new_val;
        end
      end
      assign teta_vec[gi*8 +: 8] = elem_reg;
    end
  endgenerate

  assign teta  = teta_vec;
  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_logreg_theta_update.sv
// Bench for logreg_theta_update: directed table, handshake/reset sequences,
// and random steps against an integer-arithmetic reference model.
module tb_logreg_theta_update;

  localparam int LR = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] x = '0;
  logic [7:0]  h = '0;
  logic [7:0]  y = '0;
  logic        start = 1'b0;
  logic        ready;
  logic        teta_load = 1'b0;
  logic [63:0] teta_in = '0;
  logic [63:0] teta;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  logreg_theta_update #(.LR_SHIFT(LR)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .h(h), .y(y), .start(start),
    .ready(ready), .teta_load(teta_load), .teta_in(teta_in),
    .teta(teta), .busy(busy), .done(done)
  );

  typedef struct {
    string       name;
    logic [63:0] load;
    logic [63:0] xv;
    logic [7:0]  hv;
    logic [7:0]  yv;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Reference: per-element floor((h-y)*x_j / 2^LR), subtracted and clamped.
  function automatic logic [63:0] model_step(input logic [63:0] t0, input logic [63:0] xv,
                                             input logic [7:0] hv, input logic [7:0] yv);
    int err, prod, delta, nv, div;
    logic [63:0] r;
    div = 1 << LR;
    err = int'(hv) - int'(yv);
    r = '0;
    for (int j = 0; j < 8; j++) begin
      prod = err * int'(xv[j*8 +: 8]);
      if (prod >= 0) delta = prod / div;
      else delta = -((-prod + div - 1) / div);
      nv = int'(t0[j*8 +: 8]) - delta;
      if (nv < 0) nv = 0;
      if (nv > 255) nv = 255;
      r[j*8 +: 8] = 8'(nv);
    end
    return r;
  endfunction

  task automatic do_load(input logic [63:0] v);
    teta_load = 1'b1;
    teta_in = v;
    @(posedge clk); #1;
    teta_load = 1'b0;
    chk("load", teta, v);
  endtask

  // Runs one step and checks every cycle; abuse wiggles inputs while busy.
  task automatic do_step(input string name, input logic [63:0] xv, input logic [7:0] hv,
                         input logic [7:0] yv, input bit abuse, output logic [63:0] final_t);
    logic [63:0] old_t, exp_t, part;
    old_t = teta;
    exp_t = model_step(old_t, xv, hv, yv);
    x = xv; h = hv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " busy@E0"}, {62'b0, busy, ready}, 64'h2);
    for (int j = 0; j < 8; j++) begin
      if (abuse) begin
        x = {$urandom, $urandom}; h = 8'($urandom); y = 8'($urandom);
        start = 1'b1; teta_load = j[0]; teta_in = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      start = 1'b0; teta_load = 1'b0;
      part = old_t;
      for (int k = 0; k <= j; k++) part[k*8 +: 8] = exp_t[k*8 +: 8];
      chk($sformatf("%s teta@E%0d", name, j + 1), teta, part);
      chk($sformatf("%s done/busy@E%0d", name, j + 1), {62'b0, done, busy},
          {62'b0, (j == 7), 1'b1});
    end
    @(posedge clk); #1;
    chk({name, " idle@E9"}, {61'b0, done, busy, ready}, 64'h1);
    final_t = teta;
    $display("step %s: x=%h h=%h y=%h teta %h -> %h", name, xv, hv, yv, old_t, teta);
  endtask

  initial begin
    logic [63:0] res, rl, rx;
    logic [7:0]  rh, ry;

    vecs[0] = '{"basic",   {8{8'h40}}, {8{8'h10}}, 8'h80, 8'h00, {8{8'h38}}};
    vecs[1] = '{"sat_lo",  {8{8'h02}}, {8{8'hFF}}, 8'hFF, 8'h00, 64'h0};
    vecs[2] = '{"sat_hi",  {8{8'hF0}}, {8{8'hFF}}, 8'h00, 8'hFF, {8{8'hFF}}};
    vecs[3] = '{"zero_err", 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 8'h55, 8'h55,
                64'hFEDCBA9876543210};

    #3;
    chk("reset teta", teta, 64'h0);
    chk("reset flags", {61'b0, done, busy, ready}, 64'h1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      do_load(vecs[i].load);
      do_step(vecs[i].name, vecs[i].xv, vecs[i].hv, vecs[i].yv, 1'b0, res);
      chk({vecs[i].name, " final"}, res, vecs[i].exp);
    end

    // start together with teta_load: load only.
    teta_load = 1'b1; start = 1'b1; teta_in = {8{8'h40}}; x = {8{8'h10}}; h = 8'h80; y = 8'h00;
    @(posedge clk); #1;
    teta_load = 1'b0; start = 1'b0;
    chk("load+start teta", teta, {8{8'h40}});
    chk("load+start flags", {62'b0, busy, ready}, 64'h1);
    @(posedge clk); #1;
    chk("load+start still idle", {62'b0, busy, ready}, 64'h1);
    $display("handshake: start+load gave teta=%h busy=%b", teta, busy);

    do_step("abuse", {8{8'h10}}, 8'h80, 8'h00, 1'b1, res);
    chk("abuse final", res, {8{8'h38}});

    // Reset in the middle of the basic step.
    do_load({8{8'h40}});
    x = {8{8'h10}}; h = 8'h80; y = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset partial", teta, {{4{8'h40}}, {4{8'h38}}});
    rst_n = 1'b0;
    #1;
    chk("midreset teta", teta, 64'h0);
    chk("midreset flags", {61'b0, done, busy, ready}, 64'h1);
    $display("reset mid-step: teta=%h busy=%b ready=%b", teta, busy, ready);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_load({8{8'h40}});
    do_step("post_reset", {8{8'h10}}, 8'h80, 8'h00, 1'b0, res);
    chk("post_reset final", res, {8{8'h38}});

    for (int i = 0; i < 20; i++) begin
      rl = {$urandom, $urandom}; rx = {$urandom, $urandom};
      rh = 8'($urandom); ry = 8'($urandom);
      do_load(rl);
      do_step($sformatf("rand%0d", i), rx, rh, ry, i[0], res);
      chk($sformatf("rand%0d final", i), res, model_step(rl, rx, rh, ry));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/logreg_theta_update.md
# logreg_theta_update

Training-direction counterpart of the forward hypothesis stage: given a sample vector `x`, the hypothesis `h` produced for it, and the label `y`, this block applies one gradient-descent step to a stored 8-element weight vector `teta`. It does this serially, one element per clock. It owns the weight register that feeds the forward dot-product path and exposes a start/ready/done handshake to the training controller. Learning rate is a power of two, set by parameter.

## Interface
- `LR_SHIFT`, default 8: learning-rate exponent; step = (error·x_j) >>> LR_SHIFT.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `x`  in  64  sample, 8 unsigned bytes, element j = `x[8j+7:8j]`.
- `h`  in  8  hypothesis for `x`, unsigned.
- `y`  in  8  label, unsigned.
- `start`  in  1  request one update step.
- `ready`  out  1  high in IDLE; `start`/`teta_load` accepted only then.
- `teta_load`  in  1  load `teta_in` into weight register.
- `teta_in`  in  64  initial weights, same packing as `x`.
- `teta`  out  64  current weights, registered, same packing.
- `busy`  out  1  high in UPDATE and DONE.
- `done`  out  1  one-cycle pulse when the step completes.

## Operation
- States: IDLE, UPDATE, DONE.
- IDLE:
  - `ready=1`.
  - `teta_load=1` → `teta<=teta_in` at next edge; stay IDLE.
  - Else `start=1` → capture `x`, err, idx<=0; go to UPDATE.
  - `teta_load` and `start` both high: load wins, `start` ignored.
- Error: err = {1'b0,h} − {1'b0,y}, signed 9-bit, range −255..255, computed once at capture.
- UPDATE, each cycle for element j=idx:
  - prod = err × x_j, signed 17-bit, x_j zero-extended.
  - delta = prod >>> LR_SHIFT, arithmetic shift, rounds toward −∞.
  - new = teta_j − delta, evaluated at ≥18-bit signed, saturated to [0,255].
  - Write new into teta_j; idx++.
  - After writing idx=7, go to DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Captured `x`/err are used for the whole step; changes on `x`, `h`, `y` while busy have no effect.
- `start`/`teta_load` while busy are ignored, not queued.
- Only the element at idx changes per cycle; all other elements hold.
- Reset, including mid-step: state IDLE, `teta=0`, idx=0, `done=0`, `busy=0`, `ready=1`. The partial update is discarded.

## Timing
- Reset values: `teta=64'h0`, `ready=1`, `busy=0`, `done=0`.
- `start` sampled at edge E0.
- Element j updated at edge E(j+1), j=0..7; `teta` visible updated after each edge.
- `done=1` and `busy=1` between E8 and E9.
- `ready=1` again after E9; next `start` can be sampled at E9.
- Throughput: one step per 9 cycles.
- `teta_load` takes effect at the sampling edge, one-cycle latency.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- Basic step: load all `8'h40`; x all `8'h10`, h=`8'h80`, y=0, start.
  - err=128, prod=2048, delta=8.
  - Every element becomes `8'h38`, element j changing at E(j+1).
  - `done` pulses exactly in cycle E8–E9.
- Low saturation: load all `8'h02`; x all `8'hFF`, h=`8'hFF`, y=0.
  - delta=254 → all elements clamp to `8'h00`.
- Negative error / high saturation: load all `8'hF0`; x all `8'hFF`, h=0, y=`8'hFF`.
  - prod=−65025, delta=−255 (floor) → all elements clamp to `8'hFF`.
- Zero error plus mixed x: h=y=`8'h55`, x=`64'h0123456789ABCDEF`, teta loaded `64'hFEDCBA9876543210`.
  - `teta` unchanged; `done` still pulses 9 cycles after start.
- Handshake abuse:
  - `start`+`teta_load` together in IDLE → load only, no `busy`.
  - `start` and changed `x`/`h` pulsed during UPDATE → ignored, result equals the basic-step values.
- Reset mid-step: assert `rst_n=0` after E4 of the basic step.
  - Immediately `teta=0`, `busy=0`, `ready=1`.
  - After release, a fresh load+step behaves as the basic step.
